// File: rtl/dside_uncached_responder_pkg.sv
// Shared constants and types for the uncached data-side AXI responder.
package dside_uncached_responder_pkg;

  // AXI AxSIZE encodings for byte, halfword and word beats
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;

  // Level of reset_i that holds the block in reset
  localparam logic RST_ENABLE = 1'b0;

  // ID driven on arid/awid unless overridden
  localparam logic [3:0] AXI_ID_DEFAULT = 4'b0001;

  // Sequencer states; one AXI transaction in flight at most
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_AR     = 3'd1,
    ST_R      = 3'd2,
    ST_AW_W   = 3'd3,
    ST_B      = 3'd4,
    ST_RESP_R = 3'd5,
    ST_RESP_W = 3'd6
  } state_e;

endpackage

// File: rtl/dside_uncached_responder_wstrb_decode.sv
// Maps a byte-enable pattern to the AXI beat size and the low address
// bits of the first enabled byte. Irregular patterns go out as a full word.
module dside_wstrb_decode
  import dside_uncached_responder_pkg::*;
(
  input  logic [3:0] wen_i,
  output logic [2:0] awsize_o,
  output logic [1:0] awoff_o
);

  // Size and offset lookup for every legal strobe pattern
  always_comb begin
    awsize_o = SIZE_W;
    awoff_o  = 2'b00;
    case (wen_i)
      4'b1111: begin awsize_o = SIZE_W; awoff_o = 2'b00; end
      4'b0011: begin awsize_o = SIZE_H; awoff_o = 2'b00; end
      4'b1100: begin awsize_o = SIZE_H; awoff_o = 2'b10; end
      4'b0001: begin awsize_o = SIZE_B; awoff_o = 2'b00; end
      4'b0010: begin awsize_o = SIZE_B; awoff_o = 2'b01; end
      4'b0100: begin awsize_o = SIZE_B; awoff_o = 2'b10; end
      4'b1000: begin awsize_o = SIZE_B; awoff_o = 2'b11; end
      default: begin awsize_o = SIZE_W; awoff_o = 2'b00; end
    endcase
  end

endmodule

// File: rtl/dside_uncached_responder.sv
// Uncached (kseg1) data-side responder: turns single-beat SRAM-style
// read/write requests into one AXI4 transaction at a time. One read that
// arrives while busy is parked in a single-entry pending slot.
module dside_uncached_responder
  import dside_uncached_responder_pkg::*;
#(
  parameter logic [3:0] AXI_ID = AXI_ID_DEFAULT,
  parameter int         ADDR_W = 32
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_ren_i,
  input  logic [3:0]        req_wen_i,
  input  logic [31:0]       req_wdata_i,
  output logic              read_ok_o,
  output logic              write_ok_o,
  output logic [31:0]       rdata_o,
  output logic              busy_o,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [3:0]        awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [7:0]        awlen,
  output logic [2:0]        awsize,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [3:0]        bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  state_e            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        wen_q, wen_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [1:0]        awoff_q, awoff_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              read_ok_q, read_ok_d;
  logic              write_ok_q, write_ok_d;
  logic              busy_q, busy_d;
  logic [2:0]        dec_size_s;
  logic [1:0]        dec_off_s;
  logic              aw_done_s;
  logic              w_done_s;

  // IDs and response codes are not used: one transaction is ever in flight
  // and errors are returned to the CPU as ordinary data.
  logic unused_axi_s;
  assign unused_axi_s = ^{rid, rresp, bid, bresp};

  dside_wstrb_decode u_wstrb_decode (
    .wen_i    (req_wen_i),
    .awsize_o (dec_size_s),
    .awoff_o  (dec_off_s)
  );

  // A channel counts as done once its handshake has happened (valid already
  // dropped) or is happening in this cycle.
  assign aw_done_s = !awvalid_q || awready;
  assign w_done_s  = !wvalid_q  || wready;

  // Next-state and next-output computation for the request sequencer
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    awsize_d     = awsize_q;
    awoff_d      = awoff_q;
    rdata_d      = rdata_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    read_ok_d    = 1'b0;
    write_ok_d   = 1'b0;

    // Reads arriving mid-transaction park in the slot; newest one wins
    if (req_ren_i && (state_q != ST_IDLE)) begin
      pend_valid_d = 1'b1;
      pend_addr_d  = req_addr_i;
    end else begin
      pend_addr_d = pend_addr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          // A read arriving in the same cycle refills the slot
          addr_d       = pend_addr_q;
          pend_valid_d = req_ren_i;
          pend_addr_d  = req_ren_i ? req_addr_i : pend_addr_q;
          arvalid_d    = 1'b1;
          state_d      = ST_AR;
        end else if (req_ren_i) begin
          addr_d    = req_addr_i;
          arvalid_d = 1'b1;
          state_d   = ST_AR;
        end else if (req_wen_i != 4'b0000) begin
          addr_d    = req_addr_i;
          wen_d     = req_wen_i;
          wdata_d   = req_wdata_i;
          awsize_d  = dec_size_s;
          awoff_d   = dec_off_s;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_AW_W;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid && rlast) begin
          rready_d  = 1'b0;
          rdata_d   = rdata;
          read_ok_d = 1'b1;
          state_d   = ST_RESP_R;
        end else begin
          state_d = ST_R;
        end
      end
      ST_AW_W: begin
        awvalid_d = awvalid_q && !awready;
        wvalid_d  = wvalid_q && !wready;
        if (aw_done_s && w_done_s) begin
          bready_d = 1'b1;
          state_d  = ST_B;
        end else begin
          state_d = ST_AW_W;
        end
      end
      ST_B: begin
        if (bvalid) begin
          bready_d   = 1'b0;
          write_ok_d = 1'b1;
          state_d    = ST_RESP_W;
        end else begin
          state_d = ST_B;
        end
      end
      ST_RESP_R: state_d = ST_IDLE;
      ST_RESP_W: state_d = ST_IDLE;
      default: begin
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || pend_valid_d;
  end

  // State and output registers; reset abandons any transaction in flight
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (reset_i == RST_ENABLE) begin
      state_q      <= ST_IDLE;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      addr_q       <= '0;
      wen_q        <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      awsize_q     <= 3'd0;
      awoff_q      <= 2'b00;
      rdata_q      <= 32'h0000_0000;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      read_ok_q    <= 1'b0;
      write_ok_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      awsize_q     <= awsize_d;
      awoff_q      <= awoff_d;
      rdata_q      <= rdata_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      read_ok_q    <= read_ok_d;
      write_ok_q   <= write_ok_d;
      busy_q       <= busy_d;
    end
  end

  assign read_ok_o  = read_ok_q;
  assign write_ok_o = write_ok_q;
  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = SIZE_W;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = AXI_ID;
  assign awaddr  = {addr_q[ADDR_W-1:2], awoff_q};
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_dside_uncached_responder.sv
// Directed bench for dside_uncached_responder with a small AXI slave model.
module tb_dside_uncached_responder;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [31:0] req_addr_i;
  logic        req_ren_i;
  logic [3:0]  req_wen_i;
  logic [31:0] req_wdata_i;
  logic        read_ok_o, write_ok_o, busy_o;
  logic [31:0] rdata_o;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rready, rlast, rvalid;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  int checks = 0;
  int errors = 0;

  // slave knobs and state
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] r_xor = 32'h0;
  logic [31:0] araddr_lat = 32'h0;

  // handshake / pulse counters
  int ar_hs = 0, aw_hs = 0, rok_n = 0, wok_n = 0;

  always #5 clock_i = ~clock_i;

  dside_uncached_responder dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .req_addr_i(req_addr_i), .req_ren_i(req_ren_i), .req_wen_i(req_wen_i),
    .req_wdata_i(req_wdata_i), .read_ok_o(read_ok_o), .write_ok_o(write_ok_o),
    .rdata_o(rdata_o), .busy_o(busy_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // slave responds on the falling edge with programmable wait cycles
  always @(negedge clock_i) begin
    arready <= arvalid && (ar_cnt >= ar_dly);
    ar_cnt  <= arvalid ? ar_cnt + 1 : 0;
    if (arvalid) araddr_lat <= araddr;
    awready <= awvalid && (aw_cnt >= aw_dly);
    aw_cnt  <= awvalid ? aw_cnt + 1 : 0;
    wready  <= wvalid && (w_cnt >= w_dly);
    w_cnt   <= wvalid ? w_cnt + 1 : 0;
    rvalid  <= rready && (r_cnt >= r_dly);
    r_cnt   <= rready ? r_cnt + 1 : 0;
    rdata   <= araddr_lat ^ r_xor;
    rlast   <= 1'b1;
    rid     <= 4'b0001;
    rresp   <= 2'b00;
    bvalid  <= bready && (b_cnt >= b_dly);
    b_cnt   <= bready ? b_cnt + 1 : 0;
    bid     <= 4'b0001;
    bresp   <= 2'b00;
  end

  // count handshakes and ok pulses
  always @(posedge clock_i) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (read_ok_o) rok_n <= rok_n + 1;
    if (write_ok_o) wok_n <= wok_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // wait on a DUT output at falling edges, bounded by a cycle budget
  task automatic wait_sig(input int sel, input int budget, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock_i);
      case (sel)
        0: seen = read_ok_o;
        1: seen = write_ok_o;
        2: seen = arvalid;
        3: seen = awvalid;
        default: seen = 1'b0;
      endcase
    end
    check(name, {31'b0, seen}, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock_i);
    req_addr_i = a; req_ren_i = 1'b1; r_xor = a ^ d;
    @(negedge clock_i);
    req_ren_i = 1'b0;
    check("rd_arvalid", {31'b0, arvalid}, 32'd1);
    check("rd_araddr", araddr, a);
    check("rd_arsize", {29'b0, arsize}, 32'd2);
    check("rd_arlen_arid", {20'b0, arlen, arid}, {20'b0, 8'd0, 4'b0001});
    @(negedge clock_i);
    check("rd_rready", {31'b0, rready}, 32'd1);
    @(negedge clock_i);
    check("rd_read_ok", {31'b0, read_ok_o}, 32'd1);
    check("rd_rdata", rdata_o, d);
    @(negedge clock_i);
    check("rd_ok_pulse", {31'b0, read_ok_o}, 32'd0);
    check("rd_busy", {31'b0, busy_o}, 32'd0);
    check("rd_rdata_hold", rdata_o, d);
  endtask

  task automatic do_write(input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input logic [31:0] exp_aw);
    int aw0;
    aw0 = aw_hs;
    @(negedge clock_i);
    req_addr_i = a; req_wen_i = wen; req_wdata_i = d;
    @(negedge clock_i);
    check("wr_valids", {30'b0, awvalid, wvalid}, 32'd3);
    check("wr_awaddr", awaddr, exp_aw);
    check("wr_awsize", {29'b0, awsize}, {29'b0, sz});
    check("wr_wstrb", {28'b0, wstrb}, {28'b0, wen});
    check("wr_wdata", wdata, d);
    check("wr_lens", {23'b0, awlen, wlast}, 32'd1);
    @(negedge clock_i);
    @(negedge clock_i);
    check("wr_write_ok", {31'b0, write_ok_o}, 32'd1);
    @(negedge clock_i);
    check("wr_ok_pulse", {31'b0, write_ok_o}, 32'd0);
    req_wen_i = 4'b0000;
    @(negedge clock_i);
    check("wr_no_dup_aw", aw_hs - aw0, 32'd1);
    check("wr_idle", {30'b0, awvalid, busy_o}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rd_vec_t;

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] awaddr;
  } wr_vec_t;

  rd_vec_t rd_tab[3];
  wr_vec_t wr_tab[9];

  initial begin
    int aw_n, w_n, b_first, ok_at, rok0, ar0, aw0;

    rd_tab[0] = '{32'h1FAF_F020, 32'hDEAD_BEEF};
    rd_tab[1] = '{32'h1FC0_0004, 32'h0000_0000};
    rd_tab[2] = '{32'h0000_0008, 32'hFFFF_FFFF};

    wr_tab[0] = '{4'b0100, 32'h1FAF_F000, 32'h0012_0000, 3'd0, 32'h1FAF_F002};
    wr_tab[1] = '{4'b1100, 32'h1FAF_F010, 32'hABCD_0000, 3'd1, 32'h1FAF_F012};
    wr_tab[2] = '{4'b0011, 32'h1FAF_F016, 32'h0000_1234, 3'd1, 32'h1FAF_F014};
    wr_tab[3] = '{4'b1111, 32'h1FAF_F023, 32'hCAFE_F00D, 3'd2, 32'h1FAF_F020};
    wr_tab[4] = '{4'b1000, 32'h1FAF_F005, 32'h5A00_0000, 3'd0, 32'h1FAF_F007};
    wr_tab[5] = '{4'b0001, 32'h1FAF_F00B, 32'h0000_0077, 3'd0, 32'h1FAF_F008};
    wr_tab[6] = '{4'b0010, 32'h1FAF_F00C, 32'h0000_6600, 3'd0, 32'h1FAF_F00D};
    wr_tab[7] = '{4'b0101, 32'h1FAF_F033, 32'h0011_0022, 3'd2, 32'h1FAF_F030};
    wr_tab[8] = '{4'b1110, 32'h1FAF_F041, 32'h1122_3300, 3'd2, 32'h1FAF_F040};

    reset_i = 1'b0; req_addr_i = 32'h0; req_ren_i = 1'b0;
    req_wen_i = 4'b0000; req_wdata_i = 32'h0;
    repeat (3) @(negedge clock_i);
    check("rst_valids", {27'b0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check("rst_oks_busy", {29'b0, read_ok_o, write_ok_o, busy_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    reset_i = 1'b1;

    for (int i = 0; i < 3; i++) do_read(rd_tab[i].addr, rd_tab[i].data);
    for (int i = 0; i < 9; i++)
      do_write(wr_tab[i].wen, wr_tab[i].addr, wr_tab[i].wdata, wr_tab[i].size, wr_tab[i].awaddr);

    // split AW/W handshake
    aw_dly = 2; aw_n = 0; w_n = 0; b_first = 0; ok_at = 0; aw0 = aw_hs;
    @(negedge clock_i);
    req_addr_i = 32'h1FAF_F100; req_wen_i = 4'b1111; req_wdata_i = 32'h0BAD_CAFE;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clock_i);
      if (awvalid) aw_n++;
      if (wvalid) w_n++;
      if (bready && b_first == 0) b_first = i;
      if (write_ok_o && ok_at == 0) ok_at = i;
      if (i == 6) req_wen_i = 4'b0000;
    end
    @(negedge clock_i);
    check("split_awvalid_cycles", aw_n, 32'd3);
    check("split_wvalid_cycles", w_n, 32'd1);
    check("split_b_entry", b_first, 32'd4);
    check("split_write_ok_at", ok_at, 32'd5);
    check("split_one_aw", aw_hs - aw0, 32'd1);
    aw_dly = 0;

    // read B arrives while read A stalls in R; B is served from the slot
    r_dly = 5; r_xor = 32'h1111_1111; rok0 = rok_n; ar0 = ar_hs;
    @(negedge clock_i);
    req_addr_i = 32'h1FAF_0100; req_ren_i = 1'b1;
    @(negedge clock_i);
    req_ren_i = 1'b0;
    @(negedge clock_i);
    @(negedge clock_i);
    req_addr_i = 32'h1FAF_0200; req_ren_i = 1'b1;
    @(negedge clock_i);
    req_ren_i = 1'b0;
    check("pend_busy", {31'b0, busy_o}, 32'd1);
    wait_sig(0, 20, "pend_a_read_ok");
    check("pend_a_rdata", rdata_o, 32'h1FAF_0100 ^ 32'h1111_1111);
    wait_sig(2, 10, "pend_b_arvalid");
    check("pend_b_araddr", araddr, 32'h1FAF_0200);
    wait_sig(0, 20, "pend_b_read_ok");
    check("pend_b_rdata", rdata_o, 32'h1FAF_0200 ^ 32'h1111_1111);
    @(negedge clock_i);
    check("pend_two_oks", rok_n - rok0, 32'd2);
    check("pend_two_ars", ar_hs - ar0, 32'd2);
    check("pend_idle", {31'b0, busy_o}, 32'd0);
    r_dly = 0;

    // asynchronous reset while the write address phase is stalled
    aw_dly = 20;
    @(negedge clock_i);
    req_addr_i = 32'h1FAF_F200; req_wen_i = 4'b1111; req_wdata_i = 32'h1234_5678;
    @(negedge clock_i);
    @(negedge clock_i);
    check("arst_pre_awvalid", {31'b0, awvalid}, 32'd1);
    #2 reset_i = 1'b0;
    #1;
    check("arst_valids", {27'b0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    check("arst_oks_busy", {29'b0, read_ok_o, write_ok_o, busy_o}, 32'd0);
    req_wen_i = 4'b0000;
    @(negedge clock_i);
    reset_i = 1'b1; aw_dly = 0;
    @(negedge clock_i);
    check("arst_idle", {30'b0, awvalid, busy_o}, 32'd0);
    do_read(32'h1FAF_F300, 32'h0F0F_A5A5);

    // simultaneous read and write in IDLE: read first, write afterwards
    rok0 = rok_n; ar0 = ar_hs; aw0 = aw_hs; r_xor = 32'h1FAF_F040 ^ 32'h7777_8888;
    @(negedge clock_i);
    req_addr_i = 32'h1FAF_F040; req_ren_i = 1'b1;
    req_wen_i = 4'b1100; req_wdata_i = 32'hBEEF_0000;
    @(negedge clock_i);
    req_ren_i = 1'b0;
    check("sim_read_first", {30'b0, arvalid, awvalid}, 32'd2);
    wait_sig(0, 10, "sim_read_ok");
    check("sim_rdata", rdata_o, 32'h7777_8888);
    wait_sig(3, 10, "sim_awvalid");
    check("sim_awaddr", awaddr, 32'h1FAF_F042);
    check("sim_awsize", {29'b0, awsize}, 32'd1);
    check("sim_wstrb", {28'b0, wstrb}, 32'hC);
    wait_sig(1, 10, "sim_write_ok");
    @(negedge clock_i);
    req_wen_i = 4'b0000;
    @(negedge clock_i);
    check("sim_counts", {(rok_n - rok0), (ar_hs - ar0), (aw_hs - aw0)}, {32'd1, 32'd1, 32'd1});
    check("sim_idle", {31'b0, busy_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dside_uncached_responder.md
Name: dside_uncached_responder

Overview:
- Responder end of the data-cache request interface driven by the CPU-side SRAM interface. Accepts single-beat reads and writes, serves them over an AXI4 master port, and returns read_ok/write_ok plus read data.
- Sits between the CPU request arbiter and the AXI crossbar, and serves the uncached (kseg1) data path.
- Holds at most one outstanding AXI transaction. One extra read can be captured while busy.

Parameters:
- AXI_ID, 4'b0001, ID driven on arid/awid.
- ADDR_W, 32, physical address width.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous, active-low reset (0 = reset)
- req_addr_i  in  ADDR_W  physical address; valid with ren_i or wen_i
- req_ren_i  in  1  read request, one-cycle pulse
- req_wen_i  in  4  byte write enables, level, held until write_ok_o
- req_wdata_i  in  32  write data, valid while req_wen_i != 0
- read_ok_o  out  1  one-cycle pulse, rdata_o valid
- write_ok_o  out  1  one-cycle pulse, write acknowledged by B channel
- rdata_o  out  32  read data, held until next read_ok_o
- busy_o  out  1  state != IDLE or pending slot full
- arid/araddr/arlen/arsize/arvalid out 4/ADDR_W/8/3/1; arready in 1
- rid/rdata/rresp/rlast/rvalid in 4/32/2/1/1; rready out 1
- awid/awaddr/awlen/awsize/awvalid out 4/ADDR_W/8/3/1; awready in 1
- wdata/wstrb/wlast/wvalid out 32/4/1/1; wready in 1
- bid/bresp/bvalid in 4/2/1; bready out 1

Behaviour:
- Reset (reset_i = 0, asynchronous): state = IDLE, pending slot empty, all valid/ready/ok outputs 0, rdata_o = 0, address/data registers 0. A reset mid-transaction abandons it; this is legal only under global system reset.
- States: IDLE, AR, R, AW_W, B, RESP_R, RESP_W.
- IDLE priority: pending slot, then req_ren_i, then req_wen_i != 0.
  - Read: latch addr; go to AR.
  - Write: latch addr, wen, wdata; go to AW_W.
- AR: arvalid = 1, araddr = latched addr, arlen = 0, arsize = 3'd2. On arready, go to R.
- R: rready = 1. On rvalid && rlast, latch rdata into rdata_o and go to RESP_R. rresp is ignored and data is returned as-is.
- AW_W: awvalid and wvalid asserted together; each drops independently on its own handshake (two done flags). When both are done, go to B.
  - wstrb = latched wen, wlast = 1, awlen = 0.
  - awsize from wen: 4'b1111 -> 2; 4'b0011 or 4'b1100 -> 1; one-hot -> 0.
  - awaddr[1:0] = byte offset of the lowest set strobe; upper bits from latched addr.
  - Any other wen pattern is sent as-is with awsize 2 and awaddr[1:0] = 0.
- B: bready = 1. On bvalid, go to RESP_W.
- RESP_R: read_ok_o = 1 for one cycle, then IDLE. RESP_W: write_ok_o = 1 for one cycle, then IDLE.
- Latency with zero-wait AXI: read_ok_o 3 cycles after the ren_i cycle; write_ok_o 3 cycles after wen is accepted.
- Level-held wen: it is not re-accepted during RESP_W (state != IDLE). The requester drops wen in the cycle after write_ok_o, so no duplicate write is issued.
- Flush tolerance: the requester may abandon a wait. The AXI transaction always completes; its ok pulse is still generated and the requester ignores it.
- Pending slot (1 entry, reads only): a req_ren_i pulse while state != IDLE latches its addr. If the slot is already full, the newer request overwrites it. The slot is served from IDLE before new inputs.
- Writes are never buffered. wen seen while busy is retried by level once IDLE is reached.
- Simultaneous ren and wen in IDLE: the read wins. wen stays asserted and is served afterwards.

Decomposition:
- Shared package/header: AXI size encodings (SIZE_B/H/W), state encodings, RST_ENABLE-style active-low constant, default AXI ID.
- Natural sub-module: dside_wstrb_decode (combinational: wen -> awsize, awaddr[1:0]). All sequencing stays in the top module.

Test Plan:
1. Read, zero-wait slave: ren pulse at addr 0x1FAF_F020, slave returns 0xDEAD_BEEF -> AR at cycle +1 with araddr 0x1FAF_F020, arsize 2; read_ok_o pulses at +3; rdata_o = 0xDEAD_BEEF.
2. Byte write: wen 4'b0100, addr 0x1FAF_F000, wdata 0x0012_0000 -> awaddr 0x1FAF_F002, awsize 0, wstrb 0100. write_ok_o pulses once after bvalid; no second AW while wen is still high in the ok cycle.
3. Split handshake: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid is held 3 cycles, B entered only after both handshakes.
4. Abandoned read plus new read: ren A, slave stalls rvalid 5 cycles, ren B pulses during R -> A completes with read_ok_o; B is then issued from the pending slot with araddr = B; two read_ok_o pulses total.
5. Async reset: reset_i low mid-AW_W -> all valids and ok outputs 0 immediately without a clock edge; IDLE after release; the next ren is served normally.
6. Halfword write: wen 4'b1100 -> awsize 1, awaddr[1:0] = 2'b10; simultaneous ren and wen in IDLE -> read issued first, write follows.
